// File: rtl/tconv_pkg.sv
// tconv_pkg: FSM states and default datapath widths shared by the transposed-convolution blocks.
package tconv_pkg;
    typedef enum logic [2:0] {IDLE, SHIFT, FLUSH, WAIT, OUT} state_t;
    localparam int PIX_WIDTH = 8;
    localparam int SIZE_OF_FEATURE = 8;
    localparam int SIZE_OF_WEIGHT = 5;
    localparam int STRIDE = 2;
    localparam int N_PIX_IN = SIZE_OF_FEATURE * SIZE_OF_WEIGHT;
    localparam int N_PIX_OUT = N_PIX_IN - (SIZE_OF_WEIGHT - STRIDE) * (SIZE_OF_FEATURE - 1);
    localparam int IW = 2 * PIX_WIDTH * N_PIX_IN;
    localparam int OW = 2 * PIX_WIDTH * N_PIX_OUT;
endpackage

// File: rtl/tconv_row_sched_if.sv
// tconv_row_sched_if: valid/ready row stream; master drives valid/data, slave drives ready.
interface tconv_row_sched_if #(parameter int W = tconv_pkg::IW);
    logic valid;
    logic ready;
    logic [W-1:0] data;
    modport master(output valid, data, input ready);
    modport slave(input valid, data, output ready);
endinterface

// File: rtl/tconv_out_reg.sv
// tconv_out_reg: one-entry output row register; captures only when empty, holds until handshake.
module tconv_out_reg import tconv_pkg::*; #(
    parameter int W = OW
) (
    input  logic clk,
    input  logic rst,
    input  logic cap,
    input  logic [W-1:0] cap_data,
    tconv_row_sched_if.master o
);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            o.valid <= 1'b0;
            o.data <= '0;
        end else if (o.valid && o.ready) begin
            o.valid <= 1'b0;
        end else if (cap && !o.valid) begin
            o.valid <= 1'b1;
            o.data <= cap_data;
        end
endmodule

// File: rtl/tconv_row_sched.sv
// tconv_row_sched: feeds rows into the overlap-add accumulator, flushes it, and streams merged rows out.
// Define TCONV_SCHED_WDOG_EN to bound the wait for the accumulator with an ACK_TIMEOUT watchdog.
module tconv_row_sched import tconv_pkg::*; #(
    parameter int PIX_WIDTH = 8,
    parameter int SIZE_OF_FEATURE = 8,
    parameter int SIZE_OF_WEIGHT = 5,
    parameter int STRIDE = 2,
    parameter int N_PIX_IN = SIZE_OF_FEATURE * SIZE_OF_WEIGHT,
    parameter int N_PIX_OUT = N_PIX_IN - (SIZE_OF_WEIGHT - STRIDE) * (SIZE_OF_FEATURE - 1),
    parameter int ACK_TIMEOUT = 15,
    localparam int IW = 2 * PIX_WIDTH * N_PIX_IN,
    localparam int OW = 2 * PIX_WIDTH * N_PIX_OUT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic [15:0] cfg_rows,
    output logic busy,
    output logic done,
    tconv_row_sched_if.slave in_s,
    output logic acc_en_shift,
    output logic [IW-1:0] acc_data_in,
    output logic [IW/4-1:0] acc_data_strobe,
    output logic acc_rst_n,
    input  logic acc_valid_i,
    input  logic [OW-1:0] acc_data_i,
    tconv_row_sched_if.master out_s,
    output logic out_last,
    output logic err
);
    localparam int BW = $clog2(SIZE_OF_FEATURE + 1);
    state_t state;
    logic [15:0] row_cnt;
    logic [BW-1:0] beat_cnt;
    logic abort, timeout, in_hs, out_hs;
    assign in_s.ready = state == SHIFT && beat_cnt < BW'(SIZE_OF_FEATURE);
    assign in_hs = in_s.valid && in_s.ready;
    assign out_hs = out_s.valid && out_s.ready;
    assign out_last = out_s.valid && row_cnt == 16'd1;
    assign acc_data_strobe = '1;
    assign acc_rst_n = !(rst || abort);
`ifdef TCONV_SCHED_WDOG_EN
    localparam int WW = $clog2(ACK_TIMEOUT + 1);
    logic [WW-1:0] wcnt;
    assign timeout = state == WAIT && !acc_valid_i && wcnt == WW'(ACK_TIMEOUT - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wcnt <= '0;
            err <= 1'b0;
            abort <= 1'b0;
        end else begin
            wcnt <= state == WAIT ? wcnt + 1'b1 : '0;
            err <= timeout;
            abort <= timeout;
        end
`else
    logic unused_ack;
    assign unused_ack = ^ACK_TIMEOUT;
    assign timeout = 1'b0;
    assign err = 1'b0;
    assign abort = 1'b0;
`endif
    // The accumulator lags one pulse, so FLUSH adds a zero-data shift after the last beat.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            row_cnt <= '0;
            beat_cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            acc_en_shift <= 1'b0;
            acc_data_in <= '0;
        end else begin
            done <= 1'b0;
            acc_en_shift <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (cfg_rows == 16'd0) done <= 1'b1;
                    else begin
                        row_cnt <= cfg_rows;
                        beat_cnt <= '0;
                        busy <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: if (in_hs) begin
                    acc_en_shift <= 1'b1;
                    acc_data_in <= in_s.data;
                    beat_cnt <= beat_cnt + 1'b1;
                    if (beat_cnt == BW'(SIZE_OF_FEATURE - 1)) state <= FLUSH;
                end
                FLUSH: begin
                    acc_en_shift <= 1'b1;
                    acc_data_in <= '0;
                    state <= WAIT;
                end
                WAIT: if (acc_valid_i) state <= OUT;
                else if (timeout) begin
                    busy <= 1'b0;
                    state <= IDLE;
                end
                OUT: if (out_hs) begin
                    row_cnt <= row_cnt - 16'd1;
                    beat_cnt <= '0;
                    if (row_cnt == 16'd1) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        state <= IDLE;
                    end else state <= SHIFT;
                end
                default: state <= IDLE;
            endcase
        end
    tconv_out_reg #(.W(OW)) u_out (
        .clk(clk),
        .rst(rst),
        .cap(state == WAIT && acc_valid_i),
        .cap_data(acc_data_i),
        .o(out_s)
    );
endmodule

// File: tb/tb_tconv_row_sched.sv
// tb_tconv_row_sched: table-driven frame vectors plus reset, mid-row reset and accumulator-stall sequences.
module tb_tconv_row_sched;
    import tconv_pkg::*;
    typedef struct {
        int rows;
        bit gap;
        int stall;
        int lat;
        bit poke;
        bit dup;
        int exp_pulses;
        int exp_done;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] cfg_rows = '0;
    logic busy, done, acc_en_shift, acc_rst_n, out_last, err;
    logic acc_valid_i = 1'b0;
    logic [IW-1:0] acc_data_in;
    logic [IW/4-1:0] acc_data_strobe;
    logic [OW-1:0] acc_data_i = '0;
    int total = 0, bad = 0;
    vec_t vecs[6];
    tconv_row_sched_if #(.W(IW)) in_s();
    tconv_row_sched_if #(.W(OW)) out_s();
    always #5 clk = ~clk;
    tconv_row_sched dut (
        .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .busy(busy), .done(done),
        .in_s(in_s), .acc_en_shift(acc_en_shift), .acc_data_in(acc_data_in),
        .acc_data_strobe(acc_data_strobe), .acc_rst_n(acc_rst_n), .acc_valid_i(acc_valid_i),
        .acc_data_i(acc_data_i), .out_s(out_s), .out_last(out_last), .err(err)
    );
    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask
    function automatic logic [IW-1:0] bval(input int n);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(n);
        return {(IW/32){w}};
    endfunction
    function automatic logic [OW-1:0] rval(input int k);
        logic [15:0] w;
        w = 16'hA500 + 16'(k);
        return {(OW/16){w}};
    endfunction
    task automatic run_frame(input vec_t v, input string tag);
        logic [IW-1:0] q[$];
        logic [OW-1:0] held = '0;
        int cyc = 0, pulses = 0, pidx = 0, rows_out = 0, done_cyc = -1, acc_due = -1, stall_left = 0, beat = 0;
        int data_bad = 0, gap_bad = 0, last_bad = 0, busy_bad = 0, stall_bad = 0;
        bit hs_prev = 0, en_prev = 0, ov_prev = 0;
        @(negedge clk);
        start = 1'b1;
        cfg_rows = 16'(v.rows);
        in_s.data = bval(0);
        in_s.valid = 1'b1;
        out_s.ready = 1'b1;
        while (done_cyc < 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = v.poke && cyc == 5;
            cfg_rows = start ? 16'd7 : 16'(v.rows);
            if (done) begin
                done_cyc = cyc;
                check({tag, "_busy_at_done"}, busy, 0);
            end else if (busy !== (v.rows != 0)) busy_bad++;
            if (acc_en_shift) begin
                pulses++;
                if (pidx == SIZE_OF_FEATURE) begin
                    if (acc_data_in !== '0) data_bad++;
                    if (!en_prev) gap_bad++;
                    pidx = 0;
                    acc_due = cyc + v.lat;
                end else begin
                    if (!hs_prev) gap_bad++;
                    if (q.size() == 0) data_bad++;
                    else if (acc_data_in !== q.pop_front()) data_bad++;
                    pidx++;
                end
            end
            en_prev = acc_en_shift;
            acc_valid_i = cyc == acc_due || (v.dup && cyc == acc_due + 1);
            acc_data_i = cyc == acc_due ? rval(rows_out) : ~rval(rows_out);
            if (out_s.valid) begin
                if (!ov_prev) begin
                    stall_left = v.stall;
                    held = out_s.data;
                end
                if (out_s.data !== held || out_s.data !== rval(rows_out)) data_bad++;
                if (out_last !== (rows_out == v.rows - 1)) last_bad++;
                if (stall_left > 0) begin
                    out_s.ready = 1'b0;
                    stall_left--;
                    if (in_s.ready || acc_en_shift) stall_bad++;
                end else begin
                    out_s.ready = 1'b1;
                    rows_out++;
                end
            end else out_s.ready = 1'b1;
            ov_prev = out_s.valid;
            if (hs_prev) in_s.data = bval(beat);
            in_s.valid = v.gap ? !hs_prev : 1'b1;
            hs_prev = in_s.valid && in_s.ready;
            if (hs_prev) begin
                q.push_back(in_s.data);
                beat++;
            end
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        in_s.valid = 1'b0;
        acc_valid_i = 1'b0;
        check({tag, "_pulses"}, pulses, v.exp_pulses);
        check({tag, "_rows_out"}, rows_out, v.rows);
        check({tag, "_done_cycle"}, done_cyc, v.exp_done);
        check({tag, "_data_errs"}, data_bad, 0);
        check({tag, "_gap_errs"}, gap_bad, 0);
        check({tag, "_last_errs"}, last_bad, 0);
        check({tag, "_busy_errs"}, busy_bad, 0);
        check({tag, "_stall_errs"}, stall_bad, 0);
    endtask
    initial begin
        int err_cyc, err_cnt, done_seen, busy_late, rst_at_err;
        vecs[0] = '{1, 0, 0, 2, 0, 0, 9, 14};
        vecs[1] = '{2, 1, 0, 1, 0, 0, 18, 39};
        vecs[2] = '{1, 0, 20, 3, 0, 1, 9, 35};
        vecs[3] = '{3, 0, 0, 1, 0, 0, 27, 37};
        vecs[4] = '{0, 0, 0, 1, 0, 0, 0, 1};
        vecs[5] = '{2, 0, 0, 1, 1, 0, 18, 25};
        in_s.valid = 1'b0;
        in_s.data = '0;
        out_s.ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_acc_rst_n", acc_rst_n, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_s.ready, 0);
        check("rst_en_shift", acc_en_shift, 0);
        check("rst_acc_data_zero", acc_data_in == '0, 1);
        check("rst_out_valid", out_s.valid, 0);
        check("rst_out_data_zero", out_s.data == '0, 1);
        check("rst_out_last", out_last, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("run_acc_rst_n", acc_rst_n, 1);
        check("strobe_ones", acc_data_strobe == '1, 1);
        for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("v%0d", i));
        @(negedge clk);
        start = 1'b1;
        cfg_rows = 16'd1;
        in_s.data = bval(0);
        in_s.valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("midrst_beat4_pulse", acc_en_shift, 1);
        rst = 1'b1;
        #1;
        check("midrst_acc_rst_n", acc_rst_n, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_s.ready, 0);
        check("midrst_en_shift", acc_en_shift, 0);
        check("midrst_acc_data_zero", acc_data_in == '0, 1);
        check("midrst_out_valid", out_s.valid, 0);
        @(negedge clk);
        rst = 1'b0;
        in_s.valid = 1'b0;
        run_frame(vecs[0], "post_rst");
        @(negedge clk);
        start = 1'b1;
        cfg_rows = 16'd1;
        in_s.data = bval(0);
        in_s.valid = 1'b1;
        err_cyc = -1;
        err_cnt = 0;
        done_seen = 0;
        busy_late = -1;
        rst_at_err = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 9) in_s.valid = 1'b0;
            if (err) begin
                err_cnt++;
                if (err_cyc < 0) begin
                    err_cyc = c;
                    rst_at_err = acc_rst_n;
                end
            end
            if (done) done_seen++;
            if (c == 30) busy_late = busy;
        end
`ifdef TCONV_SCHED_WDOG_EN
        check("wdog_err_cycle", err_cyc, 25);
        check("wdog_err_count", err_cnt, 1);
        check("wdog_acc_rst_n", rst_at_err, 0);
        check("wdog_no_done", done_seen, 0);
        check("wdog_busy_drop", busy_late, 0);
`else
        check("hang_no_err", err_cnt, 0);
        check("hang_no_done", done_seen, 0);
        check("hang_busy_held", busy_late, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        run_frame(vecs[0], "final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tconv_row_sched.md
# tconv_row_sched

Row sequencer for the transposed-convolution overlap-add accumulator (`shift_register`). It accepts partial-product rows from the PE array over a valid/ready stream and issues exactly one `en_shift` pulse per accepted row. After the last row of a group it issues one flush pulse, waits for the accumulator's `valid_o`, and returns the merged output row on a valid/ready stream. It repeats this for a configured number of output rows per frame and reports frame completion.

## Interface
- `PIX_WIDTH`, default 8: pixel width; accumulator lanes are `2*PIX_WIDTH` wide.
- `SIZE_OF_FEATURE`, default 8: input rows merged per output row.
- `SIZE_OF_WEIGHT`, default 5: kernel size.
- `STRIDE`, default 2: transposed-convolution stride.
- `N_PIX_IN`, default `SIZE_OF_FEATURE*SIZE_OF_WEIGHT`: lanes per input beat.
- `N_PIX_OUT`, default `N_PIX_IN-(SIZE_OF_WEIGHT-STRIDE)*(SIZE_OF_FEATURE-1)`: lanes per output row.
- `ACK_TIMEOUT`, default 15: maximum WAIT cycles (watchdog build only).

Ports (`IW = 2*PIX_WIDTH*N_PIX_IN`, `OW = 2*PIX_WIDTH*N_PIX_OUT`). One clock; reset is asynchronous and active-high.
- `clk` in, 1: the single clock; all state on its rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `start` in, 1: begin a frame; ignored while `busy`.
- `cfg_rows` in, 16: output rows per frame; sampled on the accepted `start`.
- `busy` out, 1: high from the cycle after an accepted `start` until `done`.
- `done` out, 1: one-cycle pulse at frame end.
- `in_valid` in, 1: upstream row valid.
- `in_ready` out, 1: upstream row ready.
- `in_data` in, IW: upstream partial-product row.
- `acc_en_shift` out, 1: to the accumulator's `en_shift`.
- `acc_data_in` out, IW: to the accumulator's `data_in`.
- `acc_data_strobe` out, IW/4: to the accumulator's `data_strobe`; all ones.
- `acc_rst_n` out, 1: accumulator reset, driven as `!(rst | abort)`.
- `acc_valid_i` in, 1: accumulator `valid_o`.
- `acc_data_i` in, OW: accumulator `data_out`.
- `out_valid` out, 1: output row valid.
- `out_ready` in, 1: downstream ready.
- `out_data` out, OW: merged output row.
- `out_last` out, 1: marks the final row of the frame.
- `err` out, 1: watchdog timeout pulse (watchdog build only).

## Operation
- **FSM states:** IDLE, SHIFT, FLUSH, WAIT, OUT.
- **IDLE:**
  - `start` with `cfg_rows != 0` loads the row counter with `cfg_rows`, clears the beat counter, and goes to SHIFT.
  - `start` with `cfg_rows == 0` pulses `done` the next cycle and stays in IDLE.
- **SHIFT:**
  - `in_ready = 1` while `beat_cnt < SIZE_OF_FEATURE`.
  - Each handshake (`in_valid & in_ready`) registers `in_data` into `acc_data_in`, pulses `acc_en_shift` the next cycle, and increments `beat_cnt`.
  - Upstream gaps produce no pulse; the accumulator tolerates gaps.
  - On the `SIZE_OF_FEATURE`-th handshake, go to FLUSH.
- **FLUSH:** one cycle with `acc_en_shift = 1` and `acc_data_in = 0`. This is needed because the accumulator lags one pulse, so a group takes `SIZE_OF_FEATURE+1` pulses in total. Then go to WAIT.
- **WAIT:**
  - `in_ready = 0`.
  - On `acc_valid_i`, capture `acc_data_i` into the output register and go to OUT.
  - A second `acc_valid_i` arriving before the row leaves OUT is a protocol error. It is ignored and never overwrites the held row.
- **OUT:**
  - `out_valid` is held, with `out_data` stable, until `out_ready`.
  - `out_last = (row_cnt == 1)`.
  - On handshake: decrement `row_cnt` and clear `beat_cnt`. If the handshake was the last row, pulse `done` and go to IDLE; otherwise go to SHIFT.
- **Reset values:** all outputs 0 except `acc_rst_n = 0` while `rst` is high; state is IDLE.
- **Reset mid-operation:** reset asserted in any state returns the block to IDLE immediately and resets the accumulator through `acc_rst_n`. No partial row is emitted.

## Timing
- `start` accepted in cycle 0 → `busy = 1` and `in_ready = 1` in cycle 1.
- Handshake in cycle t → `acc_en_shift` high in cycle t+1 with matching `acc_data_in`.
- Back-to-back beats give back-to-back pulses; the FLUSH pulse immediately follows the last data pulse.
- `acc_valid_i` in cycle w → `out_valid` in cycle w+1.
- Best-case row period is `SIZE_OF_FEATURE + 1 + accumulator latency + 1 + 1` cycles.
- Upstream is back-pressured (`in_ready = 0`) throughout FLUSH, WAIT and OUT.

## Configuration
- `TCONV_SCHED_WDOG_EN` defined:
  - A counter runs in WAIT. If it reaches `ACK_TIMEOUT` without `acc_valid_i`, the block pulses `err` and `abort` for 1 cycle (resetting the accumulator), drops `busy`, and goes to IDLE.
  - `done` is not pulsed on timeout.
- `TCONV_SCHED_WDOG_EN` undefined:
  - WAIT waits indefinitely.
  - `err` is tied to 0 and `abort` is tied to 0.

## Structure
- **Shared package `tconv_pkg`:** the FSM state enum and the width localparams `IW`, `OW`, `N_PIX_OUT`. These are shared with the accumulator and the PE-array wrapper.
- **Sub-module `tconv_out_reg`:** the one-entry output holding register (capture, hold under back-pressure, release on handshake).

## Test plan
- **Single row, no stalls:** defaults, `cfg_rows = 1`, 8 back-to-back beats → 9 `acc_en_shift` pulses (last with data 0), one `out_valid` with `out_last = 1`, then `done`, `busy = 0`.
- **Upstream gaps:** `cfg_rows = 2`, `in_valid` toggled every other cycle → exactly 8 data pulses plus 1 flush per row, with no pulse in a gap cycle; 2 output rows, `out_last` on the 2nd only.
- **Downstream back-pressure:** `out_ready` held 0 for 20 cycles in OUT → `out_data` stable, `in_ready = 0`, no new pulses; row releases the cycle `out_ready` rises.
- **Zero rows and busy start:** `cfg_rows = 0` → `done` in cycle 1, no traffic; `start` during a frame → ignored, row count unchanged.
- **Reset mid-row:** `rst` asserted after beat 4 → `acc_rst_n = 0`, all outputs 0, IDLE; a new frame afterward completes normally.
- **Watchdog (`TCONV_SCHED_WDOG_EN` defined):** `acc_valid_i` withheld → `err` pulse 15 cycles into WAIT, no `done`, `busy` drops.
